lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store unit downstream of the ALU: takes the ALU sum as effective address plus
//  store data and funct3, and performs one data-memory access over a valid/ack handshake.
//  Does byte-lane alignment, byte enables, load extraction and sign/zero extension.
//  Detects misaligned, illegal-funct3 and timeout faults. Drives the core's stall (~req_ready).
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles mem_req may wait for mem_ack; 0 = no timeout
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   synchronous reset, active-high
//  req_valid    in   1   access request (sampled only when req_ready=1)
//  req_we       in   1   1=store, 0=load
//  req_funct3   in   3   RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr     in   32  effective address (ALU sum)
//  req_wdata    in   32  store data (rs2), right-justified
//  req_ready    out  1   1 only in IDLE; core stalls while 0
//  rsp_valid    out  1   one-cycle pulse: access finished
//  rsp_rdata    out  32  extended load data, valid with rsp_valid (0 for stores/errors)
//  rsp_err      out  2   00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
//  mem_req      out  1   memory request; held high until mem_ack
//  mem_we       out  1   memory write enable
//  mem_addr     out  32  word address {req_addr[31:2],2'b00}
//  mem_be       out  4   byte enables (stores); 4'hF for loads
//  mem_wdata    out  32  store data shifted to its byte lane
//  mem_ack      in   1   memory done; mem_rdata valid same cycle
//  mem_rdata    in   32  raw read word
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=00, mem_req=0,
//   mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0; timeout counter=0.
//  FSM: IDLE -> ACCESS (legal, aligned request accepted); IDLE -> RESP (fault detected);
//   ACCESS -> RESP on mem_ack or timeout; RESP -> IDLE unconditionally.
//  Accept: req_valid & IDLE. addr/we/funct3/be/shifted wdata are registered at accept,
//   so mem_* outputs are stable for the whole ACCESS state.
//  mem_req=1 exactly in ACCESS. On the mem_ack cycle, mem_rdata is captured and extended.
//  RESP lasts one cycle: rsp_valid=1, rsp_rdata/rsp_err registered; then back to IDLE.
//  Latency: accept at cycle N, ack at N+1 -> rsp_valid at N+2 (min 3 cycles, req to IDLE).
//  Fault path: no mem_req; rsp_valid at N+1 with the error code.
//  Fault priority: illegal funct3 (loads 011/110/111; stores >=011) over misaligned
//   (H: addr[0]!=0; W: addr[1:0]!=0).
//  Store lanes: SB be=0001<<a[1:0], wdata={4{b}}; SH be=0011<<a[1:0], wdata={2{h}}; SW be=F.
//  Load extract: byte=rdata>>(8*a[1:0]); half=rdata>>(16*a[1]); B/H sign-extend; BU/HU zero.
//  Timeout: counter clears on entering ACCESS and increments per ACCESS cycle without ack.
//   When count reaches TIMEOUT_CYCLES-1 without ack: drop mem_req, RESP with err=10.
//   An ack on that same cycle wins (normal completion).
//  mem_ack outside ACCESS is ignored. req_valid outside IDLE is ignored (core stalls).
//  Reset mid-access: next cycle is IDLE with mem_req=0; no rsp_valid; late ack ignored.
// STRUCTURE
//  lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU), state enum {IDLE,ACCESS,RESP},
//   error enum {ERR_NONE,ERR_MISALIGN,ERR_TIMEOUT,ERR_ILLEGAL}.
//  Sub-module lsu_align (combinational): store be/lane shift and load extract/extend.
//  lsu_ctrl contains the FSM, capture registers and timeout counter.
// TESTING
//  SW addr=0x100 wdata=0xDEADBEEF, ack at N+1 -> mem_be=F, mem_wdata=DEADBEEF, rsp ok at N+2
//  SB addr=0x103 wdata=0x000000A5 -> mem_addr=0x100, be=1000, mem_wdata=A5A5A5A5
//  LB/LBU addr=0x102, mem_rdata=0x12F45678 -> rdata 0xFFFFFFF4 / 0x000000F4
//  LH addr=0x101 -> no mem_req, rsp_valid at N+1, err=01; funct3=011 load -> err=11
//  TIMEOUT_CYCLES=4, never ack -> mem_req high 4 cycles, then RESP err=10, req_ready back
//  rst asserted 2 cycles into ACCESS, ack 1 cycle later -> mem_req=0, no rsp_valid

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10,
      ERR_ILLEGAL  = 2'b11
   } err_e;

   // Stores have no unsigned forms, so anything above W is illegal for them.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we) return f3 > F3_W;
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_H, F3_HU: return off[0];
         F3_W:        return off != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / lane replication and load extract / extend.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]      st_funct3,
   input  logic [1:0]      st_off,
   input  logic [XLEN-1:0] st_data,
   output logic [3:0]      st_be,
   output logic [XLEN-1:0] st_wdata,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_off,
   input  logic [XLEN-1:0] ld_raw,
   output logic [XLEN-1:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      st_be    = 4'hF;
      st_wdata = st_data;
      case (st_funct3)
         F3_B: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         F3_H: begin
            st_be    = 4'b0011 << st_off;
            st_wdata = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = ld_raw[7:0];
      case (ld_off)
         2'd1:    ld_byte = ld_raw[15:8];
         2'd2:    ld_byte = ld_raw[23:16];
         2'd3:    ld_byte = ld_raw[31:24];
         default: ;
      endcase
      ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
   end

   always_comb begin
      ld_data = ld_raw;
      case (ld_funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data = {24'd0, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data = {16'd0, ld_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one data-memory access per request over a valid/ack handshake,
// with fault detection and a bounded wait for the memory acknowledge.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            req_ready,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic [1:0]      rsp_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit          TO_EN = TIMEOUT_CYCLES != 0;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_e          state;
   logic [CNT_W-1:0] cnt;
   logic            cap_we;
   logic [2:0]      cap_f3;
   logic [1:0]      cap_off;

   logic            req_ill_c;
   logic            req_mis_c;
   logic            timeout_hit_c;
   logic [3:0]      st_be_c;
   logic [XLEN-1:0] st_wdata_c;
   logic [XLEN-1:0] ld_data_c;

   assign req_ill_c     = f3_illegal(req_we, req_funct3);
   assign req_mis_c     = f3_misaligned(req_funct3, req_addr[1:0]);
   assign timeout_hit_c = TO_EN && (cnt == CNT_LAST);

   lsu_align u_align (
      .st_funct3 (req_funct3),
      .st_off    (req_addr[1:0]),
      .st_data   (req_wdata),
      .st_be     (st_be_c),
      .st_wdata  (st_wdata_c),
      .ld_funct3 (cap_f3),
      .ld_off    (cap_off),
      .ld_raw    (mem_rdata),
      .ld_data   (ld_data_c)
   );

   // FSM with registered outputs; mem_* are captured at accept and held through ACCESS.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_we    <= 1'b0;
         cap_f3    <= 3'd0;
         cap_off   <= 2'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= ERR_NONE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'd0;
         mem_wdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (req_ill_c || req_mis_c) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= '0;
                     rsp_err   <= req_ill_c ? ERR_ILLEGAL : ERR_MISALIGN;
                  end else begin
                     state     <= ACCESS;
                     cnt       <= '0;
                     cap_we    <= req_we;
                     cap_f3    <= req_funct3;
                     cap_off   <= req_addr[1:0];
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                     mem_be    <= req_we ? st_be_c : 4'hF;
                     mem_wdata <= req_we ? st_wdata_c : '0;
                  end
               end
            end
            ACCESS: begin
               // An ack in the final allowed cycle still completes normally.
               if (mem_ack) begin
                  state     <= RESP;
                  mem_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= cap_we ? '0 : ld_data_c;
                  rsp_err   <= ERR_NONE;
               end else if (timeout_hit_c) begin
                  state     <= RESP;
                  mem_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_err   <= ERR_TIMEOUT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               mem_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized scoreboard bench for lsu_ctrl with a short timeout so both ack and timeout paths are hit.
module tb_lsu_ctrl;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  err;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rules: legality, alignment, lanes and extension from plain arithmetic.
   function automatic bit m_legal(input bit we, input int f3);
      if (we) return f3 <= 2;
      return f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5;
   endfunction

   function automatic int m_size(input int f3);
      return 1 << (f3 % 4);
   endfunction

   function automatic logic [31:0] m_load(input int f3, input int off, input logic [31:0] raw);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'((raw >> (8 * off)) & 32'hFF);
      h = 16'((raw >> (16 * (off / 2))) & 32'hFFFF);
      case (f3)
         0:       return 32'(int'($signed(b)));
         4:       return 32'(b);
         1:       return 32'(int'($signed(h)));
         5:       return 32'(h);
         default: return raw;
      endcase
   endfunction

   function automatic logic [3:0] m_be(input int f3, input int off);
      if (f3 == 0) return 4'(1 << off);
      if (f3 == 1) return 4'(3 << off);
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
      if (f3 == 0) return (d & 32'hFF) * 32'h01010101;
      if (f3 == 1) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   // Monitor: every response must match the oldest expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_rdata", rsp_rdata, e.rdata);
         end
      end
   end

   // One request; delay = ACCESS cycles before ack (>= TO means never acked).
   task automatic do_txn(input bit we, input int f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] raw, input int delay);
      int   off;
      int   i;
      int   mreq_cycles;
      bit   done;
      exp_t e;
      off = int'(addr & 32'h3);
      i = 0;
      while (req_ready !== 1'b1 && i < 10) begin
         @(posedge clk); #1;
         i++;
      end
      if (req_ready !== 1'b1) chk("ready_wait", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = 3'(f3);
      req_addr   = addr;
      req_wdata  = wdata;
      mem_ack    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_ack   = 1'b0;
      req_we     = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (!m_legal(we, f3) || (int'(addr) % m_size(f3)) != 0) begin
         e.err   = !m_legal(we, f3) ? 2'b11 : 2'b01;
         e.rdata = 32'd0;
         exp_q.push_back(e);
         chk("fault_no_mem_req", 32'(mem_req), 32'd0);
         chk("fault_rsp_valid", 32'(rsp_valid), 32'd1);
      end else begin
         chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
         chk("mem_we", 32'(mem_we), 32'(we));
         chk("mem_be", 32'(mem_be), we ? 32'(m_be(f3, off)) : 32'hF);
         if (we) chk("mem_wdata", mem_wdata, m_wdata(f3, wdata));
         i = 0;
         done = 1'b0;
         mreq_cycles = 0;
         while (!done) begin
            if (mem_req === 1'b1) mreq_cycles++;
            if (i == delay) begin
               mem_ack   = 1'b1;
               mem_rdata = raw;
               e.err     = 2'b00;
               e.rdata   = we ? 32'd0 : m_load(f3, off, raw);
               exp_q.push_back(e);
               done = 1'b1;
            end else if (i == int'(TO) - 1) begin
               e.err   = 2'b10;
               e.rdata = 32'd0;
               exp_q.push_back(e);
               done = 1'b1;
            end else begin
               req_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            req_valid = 1'b0;
            i++;
         end
         chk("mem_req_cycles", 32'(mreq_cycles), 32'((delay < int'(TO)) ? delay + 1 : int'(TO)));
         chk("mem_req_dropped", 32'(mem_req), 32'd0);
         chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
      end
      @(posedge clk); #1;
      chk("ready_after_rsp", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);

      do_txn(1'b1, 2, 32'h100, 32'hDEADBEEF, 32'h0, 0);
      do_txn(1'b1, 0, 32'h103, 32'h000000A5, 32'h0, 0);
      do_txn(1'b0, 0, 32'h102, 32'h0, 32'h12F45678, 0);
      do_txn(1'b0, 4, 32'h102, 32'h0, 32'h12F45678, 1);
      do_txn(1'b0, 1, 32'h101, 32'h0, 32'h0, 0);
      do_txn(1'b0, 3, 32'h100, 32'h0, 32'h0, 0);
      do_txn(1'b1, 5, 32'h101, 32'h0, 32'h0, 0);
      do_txn(1'b0, 2, 32'h200, 32'h0, 32'h11223344, 100);
      do_txn(1'b0, 5, 32'h302, 32'h0, 32'h8001_7FFF, int'(TO) - 1);

      // Reset in the middle of an access; the late ack must not produce a response.
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h400;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("mid_rst_mem_req_pre", 32'(mem_req), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("late_ack_mem_req", 32'(mem_req), 32'd0);
      chk("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);

      for (int n = 0; n < 300; n++) begin
         bit          we;
         int          f3;
         logic [31:0] a;
         int          d;
         we = 1'($urandom_range(0, 1));
         f3 = int'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) f3 = we ? int'($urandom_range(0, 2))
                                               : int'($urandom_range(0, 5));
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a = a & ~(32'(m_size(f3)) - 32'd1);
         d  = int'($urandom_range(0, 5));
         do_txn(we, f3, a, $urandom, $urandom, d);
      end

      repeat (4) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
